// File: rtl/m72_pkg.sv
// Shared types, per-board decode tables and helpers for the M72 CPU memory bridge.
package m72_pkg;

    // One decode table entry: the CPU window, where it lands in SDRAM, and its attributes.
    typedef struct packed {
        logic [19:0] base;
        logic [19:0] mask;
        logic [23:0] sdr_base;
        logic        writable;
        logic        enable;
    } region_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_DONE,
        ST_FAULT
    } bridge_state_t;

    // Why the access ended in FAULT; selects which error pulse (if any) fires.
    typedef enum logic [1:0] {
        FAULT_UNMAPPED,
        FAULT_WP,
        FAULT_TIMEOUT
    } fault_t;

    typedef enum logic {
        BOARD_RTYPE,
        BOARD_GALLOP
    } board_type_t;

    localparam int MAP_ENTRIES = 4;
    typedef region_t [MAP_ENTRIES-1:0] region_map_t;

    // SDRAM word-address bases of the CPU-visible memories.
    localparam logic [23:0] REGION_CPU_ROM = 24'h000000;
    localparam logic [23:0] REGION_CPU_RAM = 24'h200000;

    function automatic region_t mk_region(
        input logic [19:0] base,
        input logic [19:0] mask,
        input logic [23:0] sdr_base,
        input logic        writable,
        input logic        enable
    );
        region_t r;
        r.base     = base;
        r.mask     = mask;
        r.sdr_base = sdr_base;
        r.writable = writable;
        r.enable   = enable;
        return r;
    endfunction

    // R-Type: 256K program ROM at 0, 16K work RAM at 0x40000, ROM mirrored at 0xC0000 for the reset vector.
    localparam region_map_t M72_RTYPE_MAP = {
        mk_region(20'h00000, 20'h00000, 24'h000000,     1'b0, 1'b0),
        mk_region(20'hC0000, 20'hC0000, REGION_CPU_ROM, 1'b0, 1'b1),
        mk_region(20'h40000, 20'hFC000, REGION_CPU_RAM, 1'b1, 1'b1),
        mk_region(20'h00000, 20'hC0000, REGION_CPU_ROM, 1'b0, 1'b1)
    };

    // Gallop: same ROM layout, work RAM moved up to 0xA0000.
    localparam region_map_t M72_GALLOP_MAP = {
        mk_region(20'h00000, 20'h00000, 24'h000000,     1'b0, 1'b0),
        mk_region(20'hC0000, 20'hC0000, REGION_CPU_ROM, 1'b0, 1'b1),
        mk_region(20'hA0000, 20'hFC000, REGION_CPU_RAM, 1'b1, 1'b1),
        mk_region(20'h00000, 20'hC0000, REGION_CPU_ROM, 1'b0, 1'b1)
    };

    function automatic region_map_t board_map(input board_type_t board);
        region_map_t m;
        case (board)
            BOARD_GALLOP: m = M72_GALLOP_MAP;
            default:      m = M72_RTYPE_MAP;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/m72_region_match.sv
// Combinational priority decoder: finds the lowest-index enabled region containing addr
// and forms the SDRAM word address for it.
module m72_region_match
    import m72_pkg::*;
#(
    parameter int NUM_REGIONS = 4,
    parameter int IDX_W       = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1
) (
    input  region_t [NUM_REGIONS-1:0] region_cfg,
    input  logic [19:0]               addr,
    output logic [IDX_W-1:0]          hit_idx,
    output logic                      valid,
    output logic                      writable,
    output logic [23:0]               sdr_addr
);

    logic [NUM_REGIONS-1:0] match;
    logic [23:0]            region_addr [NUM_REGIONS];

    generate
        for (genvar gi = 0; gi < NUM_REGIONS; gi++) begin : g_region
            assign match[gi] = region_cfg[gi].enable &&
                ((addr & region_cfg[gi].mask) == (region_cfg[gi].base & region_cfg[gi].mask));
            // Offset bits are the word-address bits not covered by the mask.
            assign region_addr[gi] = region_cfg[gi].sdr_base |
                {5'b0, addr[19:1] & ~region_cfg[gi].mask[19:1]};
        end
    endgenerate

    // Scan from the highest index down so the lowest matching index is the last to win.
    always_comb begin
        hit_idx  = '0;
        valid    = 1'b0;
        writable = 1'b0;
        sdr_addr = '0;
        for (int i = NUM_REGIONS - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit_idx  = IDX_W'(i);
                valid    = 1'b1;
                writable = region_cfg[i].writable;
                sdr_addr = region_addr[i];
            end
        end
    end

endmodule

// File: rtl/m72_mem_bridge.sv
// V30 memory bridge: table-driven address decode, SDRAM request/ack handshake with
// timeout, write-protect and open-bus handling, sticky per-region hit flags.
module m72_mem_bridge
    import m72_pkg::*;
#(
    parameter int          NUM_REGIONS = 4,
    parameter int          TIMEOUT     = 255,
    parameter logic [15:0] OPEN_BUS    = 16'hFFFF
) (
    input  logic                      CLK_32M,
    input  logic                      reset_n,
    input  region_t [NUM_REGIONS-1:0] region_cfg,
    input  logic                      cpu_req,
    input  logic [19:0]               cpu_addr,
    input  logic                      cpu_we,
    input  logic [1:0]                cpu_be,
    input  logic [15:0]               cpu_din,
    output logic [15:0]               cpu_dout,
    output logic                      cpu_ready,
    output logic                      sdr_req,
    output logic [23:0]               sdr_addr,
    output logic                      sdr_we,
    output logic [1:0]                sdr_be,
    output logic [15:0]               sdr_data,
    input  logic [15:0]               sdr_q,
    input  logic                      sdr_ack,
    output logic [NUM_REGIONS-1:0]    region_hit,
    output logic                      err_wp,
    output logic                      err_timeout
);

    localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;
    localparam int CNT_W = $clog2(TIMEOUT);

    bridge_state_t state_reg, state_next;
    fault_t        fault_reg, fault_next;

    logic                   req_sync_reg;
    logic                   req_prev_reg;
    logic                   start;
    logic [CNT_W-1:0]       cnt_reg;
    logic                   we_reg;
    logic [15:0]            dout_reg;
    logic [NUM_REGIONS-1:0] region_hit_reg;
    logic [23:0]            sdr_addr_reg;
    logic                   sdr_we_reg;
    logic [1:0]             sdr_be_reg;
    logic [15:0]            sdr_data_reg;

    logic [IDX_W-1:0]       match_idx;
    logic                   match_valid;
    logic                   match_writable;
    logic [23:0]            match_sdr_addr;

    m72_region_match #(
        .NUM_REGIONS (NUM_REGIONS),
        .IDX_W       (IDX_W)
    ) u_match (
        .region_cfg (region_cfg),
        .addr       (cpu_addr),
        .hit_idx    (match_idx),
        .valid      (match_valid),
        .writable   (match_writable),
        .sdr_addr   (match_sdr_addr)
    );

    // The request flops reset to 1 so a strobe already high when reset releases is not taken as an edge.
    assign start = req_sync_reg & ~req_prev_reg;

    // State and fault-cause registers.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            state_reg <= ST_IDLE;
            fault_reg <= FAULT_UNMAPPED;
        end else begin
            state_reg <= state_next;
            fault_reg <= fault_next;
        end
    end

    // Next-state logic; an ack coinciding with the last timeout cycle is treated as success.
    always_comb begin
        state_next = state_reg;
        fault_next = fault_reg;
        case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    if (!match_valid) begin
                        state_next = ST_FAULT;
                        fault_next = FAULT_UNMAPPED;
                    end else if (cpu_we && !match_writable) begin
                        state_next = ST_FAULT;
                        fault_next = FAULT_WP;
                    end else begin
                        state_next = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (sdr_ack) begin
                    state_next = ST_DONE;
                end else if (cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_FAULT;
                    fault_next = FAULT_TIMEOUT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Request sampling, SDRAM command latch, timeout counter, read data and hit flags.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            req_sync_reg   <= 1'b1;
            req_prev_reg   <= 1'b1;
            cnt_reg        <= '0;
            we_reg         <= 1'b0;
            dout_reg       <= OPEN_BUS;
            region_hit_reg <= '0;
            sdr_addr_reg   <= '0;
            sdr_we_reg     <= 1'b0;
            sdr_be_reg     <= '0;
            sdr_data_reg   <= '0;
        end else begin
            req_sync_reg <= cpu_req;
            req_prev_reg <= req_sync_reg;

            if (state_reg == ST_IDLE && start) begin
                we_reg <= cpu_we;
                if (match_valid) begin
                    region_hit_reg[match_idx] <= 1'b1;
                end
            end

            if (state_reg == ST_IDLE && state_next == ST_REQ) begin
                sdr_addr_reg <= match_sdr_addr;
                sdr_we_reg   <= cpu_we;
                sdr_be_reg   <= cpu_be;
                sdr_data_reg <= cpu_din;
                cnt_reg      <= '0;
            end else if (state_reg == ST_REQ && state_next == ST_REQ) begin
                cnt_reg <= cnt_reg + CNT_W'(1);
            end

            if (state_reg == ST_REQ && sdr_ack && !we_reg) begin
                dout_reg <= sdr_q;
            end

            // Faulting reads return open bus; faulting writes leave the last read data alone.
            if (state_next == ST_FAULT &&
                ((state_reg == ST_IDLE && !cpu_we) || (state_reg == ST_REQ && !we_reg))) begin
                dout_reg <= OPEN_BUS;
            end
        end
    end

    assign cpu_dout    = dout_reg;
    assign cpu_ready   = (state_reg == ST_DONE) || (state_reg == ST_FAULT);
    assign sdr_req     = (state_reg == ST_REQ);
    assign sdr_addr    = sdr_addr_reg;
    assign sdr_we      = sdr_we_reg;
    assign sdr_be      = sdr_be_reg;
    assign sdr_data    = sdr_data_reg;
    assign region_hit  = region_hit_reg;
    assign err_wp      = (state_reg == ST_FAULT) && (fault_reg == FAULT_WP);
    assign err_timeout = (state_reg == ST_FAULT) && (fault_reg == FAULT_TIMEOUT);

endmodule

// File: tb/tb_m72_mem_bridge.sv
// Directed testbench for m72_mem_bridge (TIMEOUT = 8).
module tb_m72_mem_bridge;
    import m72_pkg::*;

    logic            CLK_32M = 1'b0;
    logic            reset_n;
    region_t [3:0]   cfg;
    logic            cpu_req;
    logic [19:0]     cpu_addr;
    logic            cpu_we;
    logic [1:0]      cpu_be;
    logic [15:0]     cpu_din;
    logic [15:0]     cpu_dout;
    logic            cpu_ready;
    logic            sdr_req;
    logic [23:0]     sdr_addr;
    logic            sdr_we;
    logic [1:0]      sdr_be;
    logic [15:0]     sdr_data;
    logic [15:0]     sdr_q;
    logic            sdr_ack;
    logic [3:0]      region_hit;
    logic            err_wp;
    logic            err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    // Results of the most recent access
    int          lat;
    int          req_cyc;
    int          wp_cnt;
    int          to_cnt;
    int          rdy_extra;
    logic [23:0] seen_addr;
    logic        seen_we;
    logic [1:0]  seen_be;
    logic [15:0] seen_data;

    always #5 CLK_32M = ~CLK_32M;

    m72_mem_bridge #(
        .NUM_REGIONS (4),
        .TIMEOUT     (8),
        .OPEN_BUS    (16'hFFFF)
    ) dut (
        .CLK_32M     (CLK_32M),
        .reset_n     (reset_n),
        .region_cfg  (cfg),
        .cpu_req     (cpu_req),
        .cpu_addr    (cpu_addr),
        .cpu_we      (cpu_we),
        .cpu_be      (cpu_be),
        .cpu_din     (cpu_din),
        .cpu_dout    (cpu_dout),
        .cpu_ready   (cpu_ready),
        .sdr_req     (sdr_req),
        .sdr_addr    (sdr_addr),
        .sdr_we      (sdr_we),
        .sdr_be      (sdr_be),
        .sdr_data    (sdr_data),
        .sdr_q       (sdr_q),
        .sdr_ack     (sdr_ack),
        .region_hit  (region_hit),
        .err_wp      (err_wp),
        .err_timeout (err_timeout)
    );

    // Runs one CPU access. Call at #1 after a posedge (cycle 0). Latency is the number of
    // posedges until cpu_ready is seen. sdr_ack is driven for one cycle after posedge ack_at
    // (0 = never), so it is sampled at posedge ack_at+1.
    task automatic do_access(input logic [19:0] addr, input logic we, input logic [1:0] be,
                             input logic [15:0] din, input int ack_at, input logic [15:0] q);
        lat = -1; req_cyc = 0; wp_cnt = 0; to_cnt = 0; rdy_extra = 0;
        seen_addr = 'x; seen_we = 'x; seen_be = 'x; seen_data = 'x;
        cpu_addr = addr; cpu_we = we; cpu_be = be; cpu_din = din; sdr_q = q;
        cpu_req = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge CLK_32M); #1;
            if (sdr_req) begin
                req_cyc++;
                seen_addr = sdr_addr; seen_we = sdr_we; seen_be = sdr_be; seen_data = sdr_data;
            end
            wp_cnt += int'(err_wp);
            to_cnt += int'(err_timeout);
            sdr_ack = (n == ack_at);
            if (cpu_ready) begin
                lat = n;
                break;
            end
        end
        sdr_ack = 1'b0;
        cpu_req = 1'b0;
        repeat (2) begin
            @(posedge CLK_32M); #1;
            rdy_extra += int'(cpu_ready);
        end
        $display("access addr=%05h we=%0b lat=%0d req_cycles=%0d sdr_addr=%06h wp=%0d to=%0d dout=%04h hit=%b",
                 addr, we, lat, req_cyc, seen_addr, wp_cnt, to_cnt, cpu_dout, region_hit);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge CLK_32M);
        #1;
        reset_n = 1'b1;
        @(posedge CLK_32M); #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge CLK_32M);
        #1;
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL reset_dout: got %h expected FFFF", cpu_dout); end
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", cpu_ready); end
        n_checks++; if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL reset_sdr_req: got %b expected 0", sdr_req); end
        n_checks++; if (sdr_addr !== 24'h0) begin n_fail++; $display("FAIL reset_sdr_addr: got %h expected 0", sdr_addr); end
        n_checks++; if (region_hit !== 4'b0000) begin n_fail++; $display("FAIL reset_hit: got %b expected 0000", region_hit); end
        n_checks++; if ({err_wp, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_err: got %b expected 00", {err_wp, err_timeout}); end
        reset_n = 1'b1;
        @(posedge CLK_32M); #1;
        $display("reset done");
    endtask

    task automatic test_mapped_read();
        do_access(20'h40010, 1'b0, 2'b11, 16'h0000, 3, 16'hBEEF);
        n_checks++; if (lat !== 4) begin n_fail++; $display("FAIL read_latency: got %0d expected 4", lat); end
        n_checks++; if (seen_addr !== 24'h200008) begin n_fail++; $display("FAIL read_sdr_addr: got %h expected 200008", seen_addr); end
        n_checks++; if (req_cyc !== 2) begin n_fail++; $display("FAIL read_req_cycles: got %0d expected 2", req_cyc); end
        n_checks++; if (cpu_dout !== 16'hBEEF) begin n_fail++; $display("FAIL read_dout: got %h expected BEEF", cpu_dout); end
        n_checks++; if (region_hit !== 4'b0010) begin n_fail++; $display("FAIL read_hit: got %b expected 0010", region_hit); end
        n_checks++; if (rdy_extra !== 0) begin n_fail++; $display("FAIL read_ready_pulse: got %0d extra cycles expected 0", rdy_extra); end
        n_checks++; if (wp_cnt + to_cnt !== 0) begin n_fail++; $display("FAIL read_err: got %0d pulses expected 0", wp_cnt + to_cnt); end
    endtask

    task automatic test_write_protect();
        do_access(20'h01234, 1'b1, 2'b11, 16'hDEAD, 2, 16'h0000);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL wp_latency: got %0d expected 2", lat); end
        n_checks++; if (req_cyc !== 0) begin n_fail++; $display("FAIL wp_req_cycles: got %0d expected 0", req_cyc); end
        n_checks++; if (wp_cnt !== 1) begin n_fail++; $display("FAIL wp_pulse: got %0d expected 1", wp_cnt); end
        n_checks++; if (to_cnt !== 0) begin n_fail++; $display("FAIL wp_timeout_pulse: got %0d expected 0", to_cnt); end
        n_checks++; if (cpu_dout !== 16'hBEEF) begin n_fail++; $display("FAIL wp_dout: got %h expected BEEF", cpu_dout); end
        n_checks++; if (region_hit !== 4'b0011) begin n_fail++; $display("FAIL wp_hit: got %b expected 0011", region_hit); end
    endtask

    task automatic test_unmapped();
        do_access(20'h90000, 1'b0, 2'b11, 16'h0000, 2, 16'h1234);
        n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL unmapped_latency: got %0d expected 2", lat); end
        n_checks++; if (req_cyc !== 0) begin n_fail++; $display("FAIL unmapped_req_cycles: got %0d expected 0", req_cyc); end
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL unmapped_dout: got %h expected FFFF", cpu_dout); end
        n_checks++; if (wp_cnt + to_cnt !== 0) begin n_fail++; $display("FAIL unmapped_err: got %0d pulses expected 0", wp_cnt + to_cnt); end
        n_checks++; if (region_hit !== 4'b0011) begin n_fail++; $display("FAIL unmapped_hit: got %b expected 0011", region_hit); end
    endtask

    task automatic test_mapped_write();
        do_access(20'h40020, 1'b1, 2'b01, 16'h1234, 2, 16'hAAAA);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL write_latency: got %0d expected 3", lat); end
        n_checks++; if (seen_addr !== 24'h200010) begin n_fail++; $display("FAIL write_sdr_addr: got %h expected 200010", seen_addr); end
        n_checks++; if ({seen_we, seen_be} !== 3'b101) begin n_fail++; $display("FAIL write_we_be: got %b expected 101", {seen_we, seen_be}); end
        n_checks++; if (seen_data !== 16'h1234) begin n_fail++; $display("FAIL write_data: got %h expected 1234", seen_data); end
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL write_dout: got %h expected FFFF", cpu_dout); end
    endtask

    task automatic test_timeout();
        int late_rdy;
        do_access(20'h40010, 1'b0, 2'b11, 16'h0000, 2, 16'h5A5A);
        n_checks++; if (cpu_dout !== 16'h5A5A) begin n_fail++; $display("FAIL to_pre_dout: got %h expected 5A5A", cpu_dout); end
        // No ack at all
        do_access(20'h40010, 1'b0, 2'b11, 16'h0000, 0, 16'h0000);
        n_checks++; if (req_cyc !== 8) begin n_fail++; $display("FAIL to_req_cycles: got %0d expected 8", req_cyc); end
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL to_latency: got %0d expected 10", lat); end
        n_checks++; if (to_cnt !== 1) begin n_fail++; $display("FAIL to_pulse: got %0d expected 1", to_cnt); end
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL to_dout: got %h expected FFFF", cpu_dout); end
        // Late ack must be ignored
        sdr_q = 16'h1111; sdr_ack = 1'b1;
        late_rdy = 0;
        repeat (3) begin
            @(posedge CLK_32M); #1;
            sdr_ack = 1'b0;
            late_rdy += int'(cpu_ready) + int'(sdr_req);
        end
        n_checks++; if (late_rdy !== 0) begin n_fail++; $display("FAIL late_ack_activity: got %0d expected 0", late_rdy); end
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL late_ack_dout: got %h expected FFFF", cpu_dout); end
        // Ack sampled in the final timeout cycle counts as success
        do_access(20'h40010, 1'b0, 2'b11, 16'h0000, 9, 16'hC0DE);
        n_checks++; if (lat !== 10) begin n_fail++; $display("FAIL edge_ack_latency: got %0d expected 10", lat); end
        n_checks++; if (to_cnt !== 0) begin n_fail++; $display("FAIL edge_ack_pulse: got %0d expected 0", to_cnt); end
        n_checks++; if (cpu_dout !== 16'hC0DE) begin n_fail++; $display("FAIL edge_ack_dout: got %h expected C0DE", cpu_dout); end
    endtask

    task automatic test_priority();
        cfg[0] = mk_region(20'h40000, 20'hF0000, 24'h100000, 1'b1, 1'b1);
        cfg[1] = mk_region(20'h00000, 20'h00000, 24'h000000, 1'b1, 1'b0);
        cfg[2] = mk_region(20'h4F000, 20'hFF000, 24'h300000, 1'b1, 1'b1);
        cfg[3] = mk_region(20'h00000, 20'h00000, 24'h000000, 1'b1, 1'b0);
        pulse_reset();
        do_access(20'h4F000, 1'b0, 2'b11, 16'h0000, 2, 16'h0101);
        n_checks++; if (seen_addr !== 24'h107800) begin n_fail++; $display("FAIL prio0_sdr_addr: got %h expected 107800", seen_addr); end
        n_checks++; if (region_hit !== 4'b0001) begin n_fail++; $display("FAIL prio0_hit: got %b expected 0001", region_hit); end
        cfg[0].enable = 1'b0;
        do_access(20'h4F000, 1'b0, 2'b11, 16'h0000, 2, 16'h0202);
        n_checks++; if (seen_addr !== 24'h300000) begin n_fail++; $display("FAIL prio2_sdr_addr: got %h expected 300000", seen_addr); end
        n_checks++; if (region_hit !== 4'b0101) begin n_fail++; $display("FAIL prio2_hit: got %b expected 0101", region_hit); end
        n_checks++; if (cpu_dout !== 16'h0202) begin n_fail++; $display("FAIL prio2_dout: got %h expected 0202", cpu_dout); end
    endtask

    task automatic test_reset_mid_access();
        int activity;
        cfg = board_map(BOARD_RTYPE);
        cpu_addr = 20'h40010; cpu_we = 1'b0; cpu_be = 2'b11; cpu_req = 1'b1;
        repeat (4) @(posedge CLK_32M);
        #1;
        n_checks++; if (sdr_req !== 1'b1) begin n_fail++; $display("FAIL midrst_req_before: got %b expected 1", sdr_req); end
        reset_n = 1'b0;
        @(posedge CLK_32M); #1;
        n_checks++; if (sdr_req !== 1'b0) begin n_fail++; $display("FAIL midrst_req_drop: got %b expected 0", sdr_req); end
        n_checks++; if (cpu_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_ready: got %b expected 0", cpu_ready); end
        n_checks++; if (region_hit !== 4'b0000) begin n_fail++; $display("FAIL midrst_hit: got %b expected 0000", region_hit); end
        @(posedge CLK_32M); #1;
        reset_n = 1'b1;
        activity = 0;
        repeat (6) begin
            @(posedge CLK_32M); #1;
            activity += int'(sdr_req) + int'(cpu_ready);
        end
        n_checks++; if (activity !== 0) begin n_fail++; $display("FAIL midrst_held_req: got %0d active cycles expected 0", activity); end
        cpu_req = 1'b0;
        @(posedge CLK_32M); #1;
        do_access(20'h40010, 1'b0, 2'b11, 16'h0000, 2, 16'h7777);
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL midrst_retrigger_latency: got %0d expected 3", lat); end
        n_checks++; if (cpu_dout !== 16'h7777) begin n_fail++; $display("FAIL midrst_retrigger_dout: got %h expected 7777", cpu_dout); end
        n_checks++; if (region_hit !== 4'b0010) begin n_fail++; $display("FAIL midrst_retrigger_hit: got %b expected 0010", region_hit); end
    endtask

    task automatic test_back_to_back();
        do_access(20'hC0002, 1'b0, 2'b11, 16'h0000, 2, 16'h1111);
        n_checks++; if (seen_addr !== 24'h000001) begin n_fail++; $display("FAIL b2b_rom_alias_addr: got %h expected 000001", seen_addr); end
        n_checks++; if (cpu_dout !== 16'h1111) begin n_fail++; $display("FAIL b2b_first_dout: got %h expected 1111", cpu_dout); end
        do_access(20'h43FFE, 1'b0, 2'b11, 16'h0000, 2, 16'h2222);
        n_checks++; if (seen_addr !== 24'h201FFF) begin n_fail++; $display("FAIL b2b_ram_top_addr: got %h expected 201FFF", seen_addr); end
        n_checks++; if (cpu_dout !== 16'h2222) begin n_fail++; $display("FAIL b2b_second_dout: got %h expected 2222", cpu_dout); end
        n_checks++; if (lat !== 3) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 3", lat); end
        n_checks++; if (region_hit !== 4'b0110) begin n_fail++; $display("FAIL b2b_hit: got %b expected 0110", region_hit); end
        do_access(20'h44000, 1'b0, 2'b11, 16'h0000, 2, 16'h3333);
        n_checks++; if (cpu_dout !== 16'hFFFF) begin n_fail++; $display("FAIL b2b_past_ram_dout: got %h expected FFFF", cpu_dout); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        cfg      = board_map(BOARD_RTYPE);
        reset_n  = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = '0;
        cpu_we   = 1'b0;
        cpu_be   = 2'b00;
        cpu_din  = '0;
        sdr_q    = '0;
        sdr_ack  = 1'b0;

        test_reset();
        test_mapped_read();
        test_write_protect();
        test_unmapped();
        test_mapped_write();
        test_timeout();
        test_priority();
        test_reset_mid_access();
        test_back_to_back();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/m72_mem_bridge.md
Name: m72_mem_bridge

Overview:
Parametrised successor to the fixed per-board CPU address decode.
- Decodes the V30 20-bit memory address against a runtime-loaded table of NUM_REGIONS regions. Each region has a base, a mask, an SDRAM base and a writable flag.
- Runs the SDRAM request/ack handshake and stalls the CPU with cpu_ready until data returns.
- Adds behaviour the combinational decode lacks: write-protect fault, open-bus reads, request timeout and a sticky per-region hit status.
- Sits between the CPU bus interface in m72 and the SDRAM arbiter port.

Parameters:
NUM_REGIONS, 4, number of decode table entries; lower index has higher priority.
TIMEOUT, 255, CLK_32M cycles to wait for sdr_ack before aborting; must be ≥ 2.
OPEN_BUS, 16'hFFFF, read data for unmapped or timed-out accesses.

Ports:
CLK_32M  in  1  system clock
reset_n  in  1  synchronous, active-low reset
region_cfg  in  region_t[NUM_REGIONS]  decode table, static while cpu_req is high
cpu_req  in  1  access strobe (M_IO & DBEN); the rising edge starts an access
cpu_addr  in  20  byte address
cpu_we  in  1  1 = write
cpu_be  in  2  byte enables {hi,lo}
cpu_din  in  16  write data
cpu_dout  out  16  read data, held until the next access completes
cpu_ready  out  1  one-cycle completion pulse
sdr_req  out  1  level request, held until ack
sdr_addr  out  24  word address [24:1]
sdr_we  out  1  write strobe
sdr_be  out  2  byte enables
sdr_data  out  16  write data
sdr_q  in  16  read data, valid with sdr_ack
sdr_ack  in  1  one-cycle acknowledge
region_hit  out  NUM_REGIONS  sticky hit flags; cleared by reset only
err_wp  out  1  one-cycle pulse on a write to a non-writable region
err_timeout  out  1  one-cycle pulse on timeout

Behaviour:
- Reset values: all outputs 0 except cpu_dout = OPEN_BUS. FSM goes to IDLE and the timeout counter clears. Reset mid-access drops sdr_req in the same cycle and emits no cpu_ready.
- Edge detect: cpu_req is registered. An access starts only on 0→1 while in IDLE. Edges seen in other states are ignored. Re-triggering requires cpu_req to return to 0.
- Decode, done in the start cycle, combinationally from the inputs:
  - Region i matches when (cpu_addr & mask_i) == (base_i & mask_i) and enable_i = 1.
  - The lowest matching index wins.
  - sdr_addr = sdr_base_i | (cpu_addr[19:1] & ~mask_i[19:1]), zero-extended to 24 bits.
- FSM transitions:
  - IDLE → REQ: match, and either a read or a write to a writable region.
  - IDLE → FAULT: write to a non-writable region.
  - IDLE → FAULT: no match.
  - REQ: sdr_req, sdr_addr, sdr_we, sdr_be and sdr_data are registered and held stable. REQ → DONE on sdr_ack. REQ → FAULT when the counter reaches TIMEOUT-1.
  - DONE: cpu_ready = 1 for one cycle. For reads, cpu_dout takes sdr_q as captured at ack. sdr_req deasserts the cycle after ack. DONE → IDLE.
  - FAULT: cpu_ready = 1 for one cycle. Reads set cpu_dout = OPEN_BUS. Writes are discarded. Pulses err_wp or err_timeout as applicable (none for unmapped). FAULT → IDLE.
- Latency:
  - Mapped access: cpu_ready rises 1 cycle after the cycle in which sdr_ack is sampled.
  - Ack in the first REQ cycle gives cpu_req edge → ready = 3 cycles.
  - Fault: ready 2 cycles after the edge.
- region_hit[i] is set on entry to REQ, and on a write-protect fault, for the winning region.
- Simultaneous events: sdr_ack in the same cycle as timeout expiry counts as success, with no err_timeout. A late sdr_ack arriving while not in REQ is ignored.

Decomposition:
- m72_pkg additions:
  - region_t struct: base[19:0], mask[19:0], sdr_base[23:0], writable, enable.
  - Per-board constant tables M72_RTYPE_MAP and M72_GALLOP_MAP, holding the current RAM/ROM windows with the REGION_CPU_* bases.
  - Function board_map(board_type_t) returning the table.
- Sub-module m72_region_match: purely combinational priority decoder. Outputs hit index, valid, writable and sdr_addr. Parametrised by NUM_REGIONS.

Test Plan:
1. R-Type map; read 0x40010 with sdr_ack 2 cycles after sdr_req and sdr_q = 16'hBEEF → sdr_addr = CPU_RAM base | 0x0008; cpu_dout = BEEF; region_hit[RAM] = 1; ready at edge + 4.
2. Write 0x01234 (ROM, not writable) → no sdr_req; err_wp pulse; ready at edge + 2; cpu_dout unchanged.
3. Read 0x90000 (unmapped) → no sdr_req; cpu_dout = FFFF; no error pulses; ready at edge + 2.
4. TIMEOUT = 8 and sdr_ack never asserted → sdr_req high for exactly 8 cycles; err_timeout pulse; cpu_dout = FFFF. Ack arriving 2 cycles later is ignored.
5. Two overlapping regions where index 0 masks 0xF0000 and index 2 masks 0xFF000, access 0x4F000 → index 0 wins. Then disable index 0 → index 2 wins.
6. reset_n low during REQ → sdr_req = 0 next cycle; no cpu_ready; region_hit cleared. Held cpu_req high after release → no new access until it toggles.
